fetch_decode_fifo: RTL
======================

# fetch_decode_fifo

Multi-lane FIFO between the fetch stage and the decode stage. Each cycle it accepts up to FETCH_WIDTH `fetch_decode_pack_t` entries from fetch and presents up to DECODE_WIDTH oldest entries to decode. It advertises per-lane free space back to fetch and supports a single-cycle flush on pipeline redirect. Entries are stored opaquely; payload fields are never interpreted.

## Interface
- FETCH_WIDTH, default `FETCH_WIDTH: input lanes.
- DECODE_WIDTH, default `DECODE_WIDTH: output lanes.
- DEPTH, default `FETCH_DECODE_FIFO_SIZE (16): entries; power of two, at least max(FETCH_WIDTH, DECODE_WIDTH).

Ports:
- clk  in  1  clock.
- rst  in  1  one clock; reset is asynchronous and active-low (rst = 0 resets).
- fetch_decode_fifo_data_in  in  fetch_decode_pack_t[0:FETCH_WIDTH-1]  entries from fetch.
- fetch_decode_fifo_data_in_valid  in  FETCH_WIDTH  per-lane valid.
- fetch_decode_fifo_push  in  1  write strobe.
- fetch_decode_fifo_flush  in  1  discard all contents.
- fetch_decode_fifo_data_in_enable  out  FETCH_WIDTH  bit i = at least i+1 free entries.
- fetch_decode_fifo_data_out  out  fetch_decode_pack_t[0:DECODE_WIDTH-1]  oldest entries, lane 0 = oldest.
- fetch_decode_fifo_data_out_valid  out  DECODE_WIDTH  bit i = at least i+1 occupied entries.
- fetch_decode_fifo_data_pop_valid  in  DECODE_WIDTH  decode consumes lanes.
- fetch_decode_fifo_full  out  1  count == DEPTH.
- fetch_decode_fifo_empty  out  1  count == 0.

## Operation
- State: rptr, wptr (log2(DEPTH) bits, wrap mod DEPTH), count (log2(DEPTH)+1 bits), storage[DEPTH]. Storage is not reset.
- Write: lane i is written when push & data_in_valid[i] & data_in_enable[i] and no flush.
  - Written lanes are compacted in lane order: lane i goes to wptr + popcount of the written lanes below i.
  - Pushed count = popcount of the written lanes.
  - Valid lanes without enable are dropped silently; fetch must not rely on this.
- Read: data_out[i] = storage[(rptr + i) mod DEPTH].
  - Popped count = number of leading ones of (pop_valid & data_out_valid) starting at lane 0.
  - Pop bits after the first zero are ignored.
- Update: rptr += popped, wptr += pushed, count += pushed − popped.
- Flush has highest priority: rptr = wptr = count = 0, and any push or pop in that cycle is ignored.
- data_in_enable is a thermometer code of (DEPTH − count); data_out_valid is a thermometer code of count.
- Reset values: rptr = wptr = count = 0, data_out_valid = 0, data_in_enable = all ones, full = 0, empty = 1.

## Timing
- All outputs are combinational from registered state only; there is no input-to-output path.
- Push-to-visible latency is 1 cycle: an entry written at edge N appears on data_out after edge N.
- No fall-through bypass: an entry cannot be pushed and popped in the same cycle.
- Free space freed by a pop becomes visible on data_in_enable the next cycle. Simultaneous push and pop in a full FIFO is therefore impossible; when full, only the pop takes effect.
- Pointer wrap: an index of (ptr + i) beyond DEPTH−1 wraps to 0 with no bubble.
- Flush takes effect at the next edge; outputs show empty in the following cycle.
- Asynchronous reset mid-operation clears the state immediately, independent of clk; contents are lost.

## Structure
- fetch_decode_pack_t, FETCH_WIDTH, DECODE_WIDTH and FETCH_DECODE_FIFO_SIZE stay in the shared config/common package; no new typedefs.
- One natural sub-module: lane_compact. It computes the per-lane write offset (exclusive prefix popcount) and the total pushed count for FETCH_WIDTH lanes.
- Storage, pointers and the thermometer logic stay inline.

## Test plan
- Reset, then push 4 valid lanes with pc 0x80000000–0x8000000C:
  - next cycle: data_out_valid = 4'b1111, data_out[0].pc = 0x80000000, count = 4, data_in_enable = 4'b1111.
- Push valid = 4'b1010 (pcs A, B):
  - A is stored at wptr and B at wptr+1 (compacted); count += 2.
- Fill to 14, then push 4 lanes:
  - data_in_enable = 4'b0011, so only lanes 0–1 are written; full = 1 and data_in_enable = 0 next cycle.
  - With full, push 4 and pop 2 in the same cycle: count = 14, nothing written.
- Wrap: with rptr = 14 and count = 4, pop 4'b0111:
  - rptr = 1, data_out[0] is the entry stored at index 1.
- Non-prefix pop: pop_valid = 4'b1101 with 4 occupied:
  - popped = 1.
- Flush and reset:
  - flush together with push 4 and pop 2 on 8 entries: next cycle empty = 1, count = 0, data_in_enable = 4'b1111.
  - Asserting rst low mid-cycle clears empty/valid outputs immediately.

Source files
------------

// File: rtl/fetch_decode_fifo_pkg.sv
// Shared front-end config: lane counts, queue depth and the fetch->decode payload.
// No logic, so no latency; no flow control of its own.
// Backpressure: not applicable.
package fetch_decode_fifo_pkg;

    localparam int FETCH_WIDTH            = 4;
    localparam int DECODE_WIDTH           = 4;
    localparam int FETCH_DECODE_FIFO_SIZE = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        pred_taken;
    } fetch_decode_pack_t;

endpackage

// File: rtl/fetch_decode_fifo_lane_compact.sv
// Exclusive prefix popcount of the written lanes plus their total.
// Purely combinational, zero latency.
// Backpressure: none; the caller decides which lanes are written.
module fetch_decode_fifo_lane_compact #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]          lane_wr_i,
    output logic [W-1:0][CW-1:0]  lane_off_o,
    output logic [CW-1:0]         total_o
);

    logic [CW-1:0] acc;

    always_comb begin
        acc        = '0;
        lane_off_o = '0;
        for (int i = 0; i < W; i++) begin
            lane_off_o[i] = acc;
            acc           = acc + CW'(lane_wr_i[i]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/fetch_decode_fifo.sv
// Multi-lane queue between fetch and decode, oldest entry on lane 0.
// Push-to-visible latency 1 cycle; no fall-through bypass.
// Backpressure: thermometer free-space enables to fetch, prefix pops from decode.
module fetch_decode_fifo
    import fetch_decode_fifo_pkg::*;
#(
    parameter int FETCH_WIDTH  = fetch_decode_fifo_pkg::FETCH_WIDTH,
    parameter int DECODE_WIDTH = fetch_decode_fifo_pkg::DECODE_WIDTH,
    parameter int DEPTH        = fetch_decode_fifo_pkg::FETCH_DECODE_FIFO_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  fetch_decode_pack_t       fetch_decode_fifo_data_in [0:FETCH_WIDTH-1],
    input  logic [FETCH_WIDTH-1:0]   fetch_decode_fifo_data_in_valid,
    input  logic                     fetch_decode_fifo_push,
    input  logic                     fetch_decode_fifo_flush,
    output logic [FETCH_WIDTH-1:0]   fetch_decode_fifo_data_in_enable,
    output fetch_decode_pack_t       fetch_decode_fifo_data_out [0:DECODE_WIDTH-1],
    output logic [DECODE_WIDTH-1:0]  fetch_decode_fifo_data_out_valid,
    input  logic [DECODE_WIDTH-1:0]  fetch_decode_fifo_data_pop_valid,
    output logic                     fetch_decode_fifo_full,
    output logic                     fetch_decode_fifo_empty
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int FCW = $clog2(FETCH_WIDTH + 1);
    localparam int DCW = $clog2(DECODE_WIDTH + 1);

    fetch_decode_pack_t               storage_q [DEPTH];
    logic [AW-1:0]                    rptr_q, rptr_d;
    logic [AW-1:0]                    wptr_q, wptr_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [CW-1:0]                    free_cnt;
    logic [FETCH_WIDTH-1:0]           lane_wr;
    logic [FETCH_WIDTH-1:0][FCW-1:0]  lane_off;
    logic [FCW-1:0]                   pushed;
    logic [DCW-1:0]                   popped;
    logic                             pop_run;

    assign free_cnt                = CW'(DEPTH) - count_q;
    assign fetch_decode_fifo_full  = (count_q == CW'(DEPTH));
    assign fetch_decode_fifo_empty = (count_q == '0);

    always_comb begin
        fetch_decode_fifo_data_in_enable = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            fetch_decode_fifo_data_in_enable[i] = (free_cnt >= CW'(i + 1));
        end
    end

    always_comb begin
        fetch_decode_fifo_data_out_valid = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            fetch_decode_fifo_data_out_valid[i] = (count_q >= CW'(i + 1));
            fetch_decode_fifo_data_out[i]       = storage_q[rptr_q + AW'(i)];
        end
    end

    // Enables come from registered count, so a pop never frees space for a same-cycle push.
    assign lane_wr = {FETCH_WIDTH{fetch_decode_fifo_push & ~fetch_decode_fifo_flush}}
                   & fetch_decode_fifo_data_in_valid
                   & fetch_decode_fifo_data_in_enable;

    fetch_decode_fifo_lane_compact #(
        .W  (FETCH_WIDTH),
        .CW (FCW)
    ) u_lane_compact (
        .lane_wr_i  (lane_wr),
        .lane_off_o (lane_off),
        .total_o    (pushed)
    );

    // Only the unbroken run of pops starting at lane 0 is honoured.
    always_comb begin
        popped  = '0;
        pop_run = 1'b1;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            pop_run = pop_run & fetch_decode_fifo_data_pop_valid[i]
                              & fetch_decode_fifo_data_out_valid[i];
            if (pop_run) begin
                popped = popped + DCW'(1);
            end
        end
    end

    always_comb begin
        if (fetch_decode_fifo_flush) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            rptr_d  = rptr_q + AW'(popped);
            wptr_d  = wptr_q + AW'(pushed);
            count_d = count_q + CW'(pushed) - CW'(popped);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (lane_wr[i]) begin
                storage_q[wptr_q + AW'(lane_off[i])] <= fetch_decode_fifo_data_in[i];
            end
        end
    end

endmodule
